// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised pipeline-register chain carrying a WIDTH-bit
// payload plus a valid bit through STAGES stages (stage 0 youngest).
// Each stage supports stall (hold with bubble insertion) and flush (squash
// younger stages). Optional performance counters are built only when the
// macro PIPE_STAGE_CHAIN_PERF_EN is defined; otherwise the ports read 0.
//
// Handshake: stage 0 captures in_data exactly in cycles where
// in_valid & in_ready; when in_ready is 0 the source must hold its payload.
// The output side has no ready: a payload retires in any cycle with
// out_valid & ~stall_req[STAGES-1], and the consumer samples out_data then.
module pipe_stage_chain #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall_req,
  input  logic [STAGES-1:0]       flush_req,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_flush_cnt,
  output logic [31:0]             perf_retire_cnt
);

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] stall_eff;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] nxt_valid;
  logic [WIDTH-1:0]  nxt_data [STAGES];

  // A stall holds its stage and every younger one; a flush at k kills 0..k-1.
  always_comb begin
    logic acc_s;
    logic acc_k;
    acc_s = 1'b0;
    acc_k = 1'b0;
    stall_eff = '0;
    kill = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc_s = acc_s | stall_req[i];
      stall_eff[i] = acc_s;
      kill[i] = acc_k;
      acc_k = acc_k | flush_req[i];
    end
  end

  assign in_ready = ~stall_eff[0] & ~(|flush_req);

  // Next-state for every stage; invalid stages always carry zero data.
  always_comb begin
    nxt_valid = '0;
    for (int i = 0; i < STAGES; i++) nxt_data[i] = '0;
    if (stall_eff[0]) begin
      nxt_valid[0] = valid_q[0] & ~kill[0];
      nxt_data[0]  = data_q[0];
    end else begin
      nxt_valid[0] = in_valid & ~(|flush_req);
      nxt_data[0]  = in_data;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (stall_eff[i]) begin
        nxt_valid[i] = valid_q[i] & ~kill[i];
        nxt_data[i]  = data_q[i];
      end else begin
        // A stalled predecessor leaves a bubble in the first unstalled stage.
        nxt_valid[i] = valid_q[i-1] & ~kill[i-1] & ~stall_eff[i-1];
        nxt_data[i]  = data_q[i-1];
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      if (!nxt_valid[i]) nxt_data[i] = '0;
    end
  end

  // Stage registers; reset overrides stall and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      valid_q <= nxt_valid;
      for (int i = 0; i < STAGES; i++) data_q[i] <= nxt_data[i];
    end
  end

  // Flatten the stage payloads onto the packed debug/observation bus.
  always_comb begin
    stage_data = '0;
    for (int i = 0; i < STAGES; i++) stage_data[i*WIDTH +: WIDTH] = data_q[i];
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic retire;
  assign retire = valid_q[STAGES-1] & ~stall_req[STAGES-1];

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_retire_cnt <= '0;
    end else begin
      if ((|stall_req) && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if ((|flush_req) && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (retire && (perf_retire_cnt != 32'hFFFF_FFFF))
        perf_retire_cnt <= perf_retire_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt  = 32'd0;
  assign perf_flush_cnt  = 32'd0;
  assign perf_retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain (STAGES=4, WIDTH=64): directed reset,
// streaming, stall, flush, stall+flush and counter scenarios, plus a
// randomised stall-only phase checked by an in-order scoreboard.
module tb_pipe_stage_chain;
  localparam int S = 4;
  localparam int W = 64;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [S-1:0]   stall_req;
  logic [S-1:0]   flush_req;
  logic [S-1:0]   stage_valid;
  logic [S*W-1:0] stage_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [31:0]    perf_stall_cnt;
  logic [31:0]    perf_flush_cnt;
  logic [31:0]    perf_retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_on    = 0;
  logic [W-1:0] exp_q[$];

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipe_stage_chain #(.STAGES(S), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall_req(stall_req), .flush_req(flush_req),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_retire_cnt(perf_retire_cnt)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] sdata(input int k);
    return stage_data[k*W +: W];
  endfunction

  // Drive inputs just after the inactive edge, then let them settle.
  task automatic apply(input logic v, input logic [W-1:0] d,
                       input logic [S-1:0] st, input logic [S-1:0] fl);
    in_valid  = v;
    in_data   = d;
    stall_req = st;
    flush_req = fl;
    #1;
  endtask

  // Scoreboard sampling for this cycle, then advance through one active edge.
  task automatic tick();
    if (sb_on) begin
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (out_valid && !stall_req[S-1]) begin
        if (exp_q.size() == 0) check_eq("sb_extra_retire", out_data, ~out_data);
        else check_eq("sb_retire", out_data, exp_q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(1'b0, '0, '0, '0);
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Loads s3..s0 with d0..d3 (d0 oldest).
  task automatic fill(input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic [W-1:0] d2, input logic [W-1:0] d3);
    apply(1'b1, d0, '0, '0); tick();
    apply(1'b1, d1, '0, '0); tick();
    apply(1'b1, d2, '0, '0); tick();
    apply(1'b1, d3, '0, '0); tick();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; stall_req = '0; flush_req = '0;
    @(negedge clk);

    // Reset held two cycles with a payload offered.
    apply(1'b1, 64'hAA, '0, '0); tick();
    apply(1'b1, 64'hAA, '0, '0); tick();
    reset = 1'b0;
    apply(1'b0, '0, '0, '0);
    check_eq("rst_valid", W'(stage_valid), '0);
    check_eq("rst_data", stage_data[W-1:0] | sdata(1) | sdata(2) | sdata(3), '0);
    check_eq("rst_ready", W'(in_ready), 1);
    check_eq("rst_stall_cnt", W'(perf_stall_cnt), 0);
    check_eq("rst_flush_cnt", W'(perf_flush_cnt), 0);
    check_eq("rst_retire_cnt", W'(perf_retire_cnt), 0);

    // Streaming: latency STAGES, back-to-back throughput.
    do_reset();
    sb_on = 1;
    for (int c = 0; c < 8; c++) begin
      apply(c < 3, (c < 3) ? W'(64'h10 + c) : '0, '0, '0);
      if (c >= 4 && c <= 6) begin
        check_eq("stream_valid", W'(out_valid), 1);
        check_eq("stream_data", out_data, W'(64'h10 + c - 4));
      end
      if (c == 7) check_eq("stream_empty", W'(out_valid), 0);
      tick();
    end
    check_eq("stream_sb_drained", W'(exp_q.size()), 0);
    sb_on = 0;

    // Stall stage 2: stages 0..2 hold, stage 3 retires and becomes a bubble.
    do_reset();
    fill(64'hA0, 64'hA1, 64'hA2, 64'hA3);
    apply(1'b0, '0, 4'b0100, '0);
    check_eq("stall_ready", W'(in_ready), 0);
    check_eq("stall_full", W'(stage_valid), 4'b1111);
    check_eq("stall_retire", W'(out_valid & ~stall_req[S-1]), 1);
    check_eq("stall_out", out_data, 64'hA0);
    tick();
    apply(1'b0, '0, '0, '0);
    check_eq("stall_valid", W'(stage_valid), 4'b0111);
    check_eq("stall_s0", sdata(0), 64'hA3);
    check_eq("stall_s1", sdata(1), 64'hA2);
    check_eq("stall_s2", sdata(2), 64'hA1);
    check_eq("stall_s3", sdata(3), 64'h0);

    // Flush at stage 2: stages 0,1 squashed, stage 2 advances, input refused.
    do_reset();
    fill(64'h11, 64'h10, 64'h0F, 64'h0E);
    apply(1'b1, 64'h99, '0, 4'b0100);
    check_eq("flush_ready", W'(in_ready), 0);
    tick();
    apply(1'b0, '0, '0, '0);
    check_eq("flush_valid", W'(stage_valid), 4'b1000);
    check_eq("flush_s3", sdata(3), 64'h10);
    check_eq("flush_s0", sdata(0), 64'h0);
    check_eq("flush_s1", sdata(1), 64'h0);

    // Stall and flush together: flush wins for killed stages.
    do_reset();
    fill(64'hB0, 64'hB1, 64'hB2, 64'hB3);
    apply(1'b0, '0, 4'b0010, 4'b1000);
    check_eq("sf_ready", W'(in_ready), 0);
    check_eq("sf_retire", W'(out_valid & ~stall_req[S-1]), 1);
    tick();
    apply(1'b0, '0, '0, '0);
    check_eq("sf_valid", W'(stage_valid), 4'b0000);
    check_eq("sf_data", sdata(0) | sdata(1) | sdata(2) | sdata(3), '0);

    // Random stalls, no flush: every accepted payload retires in order.
    do_reset();
    sb_on = 1;
    for (int c = 0; c < 60; c++) begin
      logic [S-1:0] st;
      st = ($urandom_range(0, 2) == 0) ? S'($urandom_range(1, (1 << S) - 1)) : '0;
      apply(1'($urandom_range(0, 1)), {$urandom, $urandom}, st, '0);
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      apply(1'b0, '0, '0, '0);
      tick();
    end
    check_eq("rand_sb_drained", W'(exp_q.size()), 0);
    sb_on = 0;

    // Counters: 5 retires, 3 stall cycles, 1 flush cycle.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c < 5)                apply(1'b1, W'(64'hC0 + c), '0, '0);
      else if (c >= 6 && c < 9) apply(1'b0, '0, 4'b0001, '0);
      else if (c == 9)          apply(1'b0, '0, '0, 4'b1000);
      else                      apply(1'b0, '0, '0, '0);
      tick();
    end
    apply(1'b0, '0, '0, '0);
    check_eq("perf_stall", W'(perf_stall_cnt), PERF ? 3 : 0);
    check_eq("perf_flush", W'(perf_flush_cnt), PERF ? 1 : 0);
    check_eq("perf_retire", W'(perf_retire_cnt), PERF ? 5 : 0);
    // Mid-stream reset with stall and flush active.
    apply(1'b1, 64'hD0, '0, '0); tick();
    apply(1'b1, 64'hD1, '0, '0); tick();
    reset = 1'b1;
    apply(1'b1, 64'hD2, 4'b0011, 4'b0100);
    tick();
    reset = 1'b0;
    apply(1'b0, '0, '0, '0);
    check_eq("mrst_valid", W'(stage_valid), '0);
    check_eq("mrst_data", sdata(0) | sdata(1), '0);
    check_eq("mrst_stall_cnt", W'(perf_stall_cnt), 0);
    check_eq("mrst_flush_cnt", W'(perf_flush_cnt), 0);
    check_eq("mrst_retire_cnt", W'(perf_retire_cnt), 0);
    check_eq("mrst_ready", W'(in_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

- Parametrised pipeline-register chain for the ARM CPU datapath.
- Replaces the hand-instantiated per-signal pipeline registers and flops between IF/ID/EX/MEM/WB.
- Carries a WIDTH-bit payload plus a valid bit through STAGES stages.
- Supports per-stage stall (back-pressure with bubble insertion) and per-stage flush (squash of younger instructions on a taken branch).

## Interface
- STAGES, 4, number of stages, legal 2..8; stage 0 is youngest, stage STAGES-1 is oldest/output.
- WIDTH, 64, payload bits per stage.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  new instruction/payload offered to stage 0.
- in_data  in  WIDTH  payload for stage 0.
- in_ready  out  1  stage 0 accepts this cycle; equals ~stall_eff[0] & ~|flush_req.
- stall_req  in  STAGES  bit k: hold stage k (and, by propagation, all younger stages).
- flush_req  in  STAGES  bit k: squash current contents of stages 0..k-1; stage k itself survives.
- stage_valid  out  STAGES  registered valid of each stage.
- stage_data  out  STAGES*WIDTH  registered payloads, stage k at [k*WIDTH +: WIDTH].
- out_valid  out  1  stage_valid[STAGES-1].
- out_data  out  WIDTH  payload of stage STAGES-1.
- perf_stall_cnt, perf_flush_cnt, perf_retire_cnt  out  32 each  performance counters (see Configuration).

## Operation
- stall_eff[i] = |stall_req[STAGES-1:i]: a stall holds the stage and every younger stage.
- kill[i] = |flush_req[STAGES-1:i+1]: current content of stage i is squashed; kill[STAGES-1] = 0.
- Stage 0:
  - if stall_eff[0], hold, with valid cleared if kill[0];
  - else valid <= in_valid & ~|flush_req, data <= in_data.
- Stage i>0:
  - if stall_eff[i], hold, with valid cleared if kill[i];
  - else valid <= stage_valid[i-1] & ~kill[i-1] & ~stall_eff[i-1], data <= stage_data[i-1].
- The ~stall_eff[i-1] term inserts a bubble into the first unstalled stage.
- Any stage whose next valid is 0 has its data loaded with 0, so bubbles are deterministic.
- Flush takes priority over stall for the killed stages: the stage holds position but becomes invalid.
- Retire happens when out_valid & ~stall_req[STAGES-1]. Retirement is informational; the downstream consumer samples out_data that cycle.
- stall_req and flush_req are level inputs, sampled every edge. No internal memory of requests.

## Timing
- Reset: every stage_valid = 0, every stage_data = 0, out_valid = 0, all counters = 0.
- in_ready = 1 after reset.
- in_ready is combinational from stall_req/flush_req; everything else is registered.
- Latency: a payload accepted in cycle c is visible on out_valid/out_data in cycle c+STAGES when there are no stalls.
- Each stall cycle on any stage at or above the payload's position adds 1 cycle.
- Throughput: 1 payload/cycle when unstalled.
- Reset asserted mid-operation clears all stages at that edge, overriding stall and flush. No partial drain.
- in_valid=1 while in_ready=0: payload not captured; the source must hold it.

## Configuration
- Macro PIPE_STAGE_CHAIN_PERF_EN.
- When defined:
  - perf_stall_cnt increments on every cycle with |stall_req;
  - perf_flush_cnt increments on every cycle with |flush_req;
  - perf_retire_cnt increments on every retire cycle.
  - All three saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: the counter ports remain present but are tied to 0, and no counter flops are built.

## Test plan
All scenarios use STAGES=4, WIDTH=64.
- Reset: hold reset 2 cycles with in_valid=1, in_data=0xAA -> stage_valid=4'b0000, stage_data all 0, in_ready=1, counters 0.
- Streaming: present 0x10, 0x11, 0x12 in cycles 0..2, no stall/flush -> out_valid=1 with out_data 0x10, 0x11, 0x12 in cycles 4, 5, 6; out_valid=0 in cycle 7.
- Stall:
  - Setup: stages full, s0..s3 = 0xA3, 0xA2, 0xA1, 0xA0; stall_req=4'b0100 for one cycle.
  - Response: in_ready=0 that cycle. Next cycle s0..s2 = 0xA3, 0xA2, 0xA1 unchanged; s3 valid=0 with data 0; 0xA0 retired.
- Flush:
  - Setup: s0..s3 = 0xE, 0xF, 0x10, 0x11; flush_req=4'b0100; in_valid=1, in_data=0x99.
  - Response: in_ready=0. Next cycle stage_valid=4'b1000 with s3 = 0x10; 0x99 not captured.
- Stall plus flush together:
  - Setup: s0..s3 full; stall_req=4'b0010, flush_req=4'b1000.
  - Response: next cycle s0 and s1 hold their data positions with valid=0 and data 0; s2 valid=0; s3 valid=0; old s3 retired.
- Perf counters (macro defined): 3 stall cycles, 1 flush cycle, 5 retires, then reset mid-stream.
  - Before reset: perf_stall_cnt=3, perf_flush_cnt=1, perf_retire_cnt=5.
  - After reset edge: all counters 0 and stage_valid=0.
  - Rebuild without the macro: counters read 0 throughout.
